// File: rtl/tnn_pkg.sv
// Shared constants and types for the TNN column datapath.
// Thermometer width defaults, count-width helper and FSM encodings.
package tnn_pkg;

    localparam int N_DEF = 16;

    function automatic int cw_of(input int n);
        return $clog2(n + 1);
    endfunction

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/therm_decode.sv
// Leading-ones decoder for a sorted thermometer code.
// count is the index of the first zero (N if none); err flags ones above it.
module therm_decode
    import tnn_pkg::*;
#(
    parameter int N = N_DEF,
    localparam int CW = cw_of(N)
) (
    input  logic [N-1:0]  therm_i,
    output logic [CW-1:0] count_o,
    output logic          err_o
);

    logic found;

    always_comb begin
        count_o = CW'(N);
        err_o   = 1'b0;
        found   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && !therm_i[i]) begin
                count_o = CW'(i);
                found   = 1'b1;
            end else if (found && therm_i[i]) begin
                err_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/therm_spike_tx.sv
// Thermometer count to temporal spike converter over an N-cycle gamma window.
// Count c spikes in slot N-c; count 0 never spikes.
module therm_spike_tx
    import tnn_pkg::*;
#(
    parameter int N = N_DEF,
    localparam int CW = cw_of(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  therm_in,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          spike_out,
    output logic          gamma_start,
    output logic          busy,
    output logic [CW-1:0] count_out,
    output logic          err
);

    localparam int SW = $clog2(N);

    state_e          state_q;
    logic [SW-1:0]   slot_q, slot_d;
    logic [CW-1:0]   count_q;
    logic            spike_q, spike_d;
    logic            gs_q, busy_q, err_q;
    logic [CW-1:0]   dec_count;
    logic            dec_err;
    logic            last, xfer;

    therm_decode #(.N(N)) u_dec (
        .therm_i (therm_in),
        .count_o (dec_count),
        .err_o   (dec_err)
    );

    assign last     = (state_q == RUN) && (slot_q == SW'(N - 1));
    assign in_ready = !rst && ((state_q == IDLE) || last);
    assign xfer     = in_valid && in_ready;

    // Outputs are registered, so decide the spike for the slot being entered.
    assign slot_d  = slot_q + 1'b1;
    assign spike_d = (count_q != '0) &&
                     ({{(CW-SW){1'b0}}, slot_d} == CW'(N) - count_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            slot_q  <= '0;
            count_q <= '0;
            spike_q <= 1'b0;
            gs_q    <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (xfer) begin
            state_q <= RUN;
            slot_q  <= '0;
            count_q <= dec_count;
            spike_q <= (dec_count == CW'(N));
            gs_q    <= 1'b1;
            busy_q  <= 1'b1;
            err_q   <= dec_err;
        end else if (state_q == RUN) begin
            gs_q  <= 1'b0;
            err_q <= 1'b0;
            if (last) begin
                state_q <= IDLE;
                slot_q  <= '0;
                spike_q <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                slot_q  <= slot_d;
                spike_q <= spike_d;
            end
        end
    end

    assign spike_out   = spike_q;
    assign gamma_start = gs_q;
    assign busy        = busy_q;
    assign count_out   = count_q;
    assign err         = err_q;

endmodule

// File: tb/tb_therm_spike_tx.sv
// Directed bench for therm_spike_tx with N=16.
// Cycle k is the interval after the k-th edge following a transfer.
module tb_therm_spike_tx;

    localparam int N  = 16;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  therm_in;
    logic          in_valid;
    logic          in_ready;
    logic          spike_out;
    logic          gamma_start;
    logic          busy;
    logic [CW-1:0] count_out;
    logic          err;

    therm_spike_tx #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .therm_in    (therm_in),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .spike_out   (spike_out),
        .gamma_start (gamma_start),
        .busy        (busy),
        .count_out   (count_out),
        .err         (err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0]   sp_v, gs_v, bz_v, rd_v, er_v;
    logic [CW-1:0] cnt_a [0:63];
    logic          zero_ok;

    typedef struct {
        logic [N-1:0] therm;
        int           cnt;
        int           er;
        int           sp_cyc;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int first1(input logic [63:0] v);
        for (int i = 0; i < 64; i++)
            if (v[i]) return i;
        return 0;
    endfunction

    task automatic xfer(input logic [N-1:0] t, input string name);
        @(negedge clk);
        therm_in = t;
        in_valid = 1'b1;
        chk({name, " ready_before"}, int'(in_ready), 1);
        @(posedge clk);
        #1;
    endtask

    // Record cycles 1..nc; optionally drop valid or pulse reset mid-run.
    task automatic record(input int nc, input int drop_at, input int rst_at);
        sp_v = '0; gs_v = '0; bz_v = '0; rd_v = '0; er_v = '0;
        zero_ok = 1'b1;
        for (int c = 1; c <= nc; c++) begin
            if (c == drop_at) in_valid = 1'b0;
            if (c == rst_at) rst = 1'b1;
            if (c == rst_at + 1) rst = 1'b0;
            #1;
            sp_v[c]  = spike_out;
            gs_v[c]  = gamma_start;
            bz_v[c]  = busy;
            rd_v[c]  = in_ready;
            er_v[c]  = err;
            cnt_a[c] = count_out;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        vecs[0] = '{16'h00FF, 8,  0, 9};
        vecs[1] = '{16'hFFFF, 16, 0, 1};
        vecs[2] = '{16'h0000, 0,  0, 0};
        vecs[3] = '{16'h0001, 1,  0, 16};
        vecs[4] = '{16'h00F7, 3,  1, 14};
        vecs[5] = '{16'h7FFF, 15, 0, 2};

        rst = 1'b1;
        therm_in = '0;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", int'(in_ready), 0);
        chk("rst_outs", int'({spike_out, gamma_start, busy, err}), 0);
        chk("rst_count", int'(count_out), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("idle_ready", int'(in_ready), 1);

        for (int v = 0; v < 6; v++) begin
            string nm;
            nm = $sformatf("v%0d_%h", v, vecs[v].therm);
            xfer(vecs[v].therm, nm);
            record(17, 1, 0);
            chk({nm, " count"}, int'(cnt_a[1]), vecs[v].cnt);
            chk({nm, " gs_cyc"}, first1(gs_v), 1);
            chk({nm, " gs_n"}, $countones(gs_v), 1);
            chk({nm, " err1"}, int'(er_v[1]), vecs[v].er);
            chk({nm, " err_n"}, $countones(er_v), vecs[v].er);
            chk({nm, " sp_cyc"}, first1(sp_v), vecs[v].sp_cyc);
            chk({nm, " sp_n"}, $countones(sp_v), vecs[v].sp_cyc != 0);
            chk({nm, " busy_n"}, $countones(bz_v), 16);
            chk({nm, " busy16"}, int'(bz_v[16]), 1);
            chk({nm, " rdy_n"}, $countones(rd_v), 2);
            chk({nm, " rdy16"}, int'(rd_v[16]), 1);
            chk({nm, " rdy17"}, int'(rd_v[17]), 1);
            chk({nm, " count_hold"}, int'(cnt_a[17]), vecs[v].cnt);
        end

        // Back-to-back: second code is taken in slot 15 with no idle gap.
        @(negedge clk);
        therm_in = 16'h000F;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        therm_in = 16'h3FFF;
        record(33, 17, 0);
        chk("b2b gs_cyc2", int'(gs_v[17]), 1);
        chk("b2b gs_mask", int'($countones(gs_v)), 2);
        chk("b2b gs_first", first1(gs_v), 1);
        chk("b2b sp_first", first1(sp_v), 13);
        chk("b2b sp19", int'(sp_v[19]), 1);
        chk("b2b sp_n", $countones(sp_v), 2);
        chk("b2b busy_n", $countones(bz_v), 32);
        chk("b2b busy33", int'(bz_v[33]), 0);
        chk("b2b cnt1", int'(cnt_a[1]), 4);
        chk("b2b cnt17", int'(cnt_a[17]), 14);

        // Reset in cycle 5 aborts the window before its cycle-13 spike.
        xfer(16'h000F, "rst_mid");
        record(20, 1, 5);
        chk("rstmid busy4", int'(bz_v[4]), 1);
        chk("rstmid rdy5", int'(rd_v[5]), 0);
        chk("rstmid sp_n", $countones(sp_v), 0);
        chk("rstmid busy_after", int'($countones(bz_v[20:6])), 0);
        chk("rstmid gs_after", int'($countones(gs_v[20:6])), 0);
        for (int c = 6; c <= 20; c++)
            if (cnt_a[c] != '0) zero_ok = 1'b0;
        chk("rstmid count_zero", int'(zero_ok), 1);
        chk("rstmid rdy_after", int'($countones(rd_v[20:6])), 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/therm_spike_tx.md
Name: therm_spike_tx

Overview:
- Converts a sorted thermometer vector (bitonic sorter output, ones packed from bit 0 upward) back into a single temporal spike within a gamma window of N cycles.
- The sorter encodes spike counts into thermometer form; this block goes the other direction and turns the count into a spike time on a 1-bit line for the next TNN column.
- Upstream side uses a valid/ready handshake. Downstream side is free-running with per-window framing pulses.

Parameters:
- N, 16, thermometer width and gamma window length in cycles; must be a power of 2, N >= 4.
- CW, $clog2(N+1), width of the count; derived, not overridable.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- therm_in  in  N  sorted thermometer code; bit 0 is the first position filled.
- in_valid  in  1  therm_in valid.
- in_ready  out  1  block can accept; transfer occurs when in_valid && in_ready on a clk edge.
- spike_out  out  1  one-cycle spike, at most one per window.
- gamma_start  out  1  high during slot 0 of every window.
- busy  out  1  window in progress.
- count_out  out  CW  decoded count of the current window, held for the whole window.
- err  out  1  one-cycle flag in slot 0 when the accepted code was malformed.

Behaviour:
- Clocking and reset: all state on clk. Reset is synchronous and active-high: clk with rst high clears state to IDLE, slot=0, and sets spike_out, gamma_start, busy, count_out and err to 0. in_ready is 0 while rst is high.
- Decode:
  - count = number of consecutive ones starting at bit 0, i.e. the index of the first 0, or N if all ones.
  - err = 1 if any 1 lies above that first 0.
  - popcount is not used; a malformed code still yields the leading-ones count.
- FSM IDLE:
  - in_ready=1, busy=0, all pulse outputs 0.
  - On transfer: latch count and err, go to RUN with slot=0.
- FSM RUN:
  - slot counts 0..N-1; one slot per cycle.
  - Transfer at edge t puts slot 0 in cycle t+1, so latency from transfer to gamma_start is 1 cycle.
  - gamma_start=1 and err=latched err only in slot 0.
  - spike_out=1 exactly when slot == N-count and count != 0. So count N spikes in slot 0, count 1 in slot N-1, count 0 never spikes.
  - busy=1 throughout RUN. count_out holds the latched count.
- Window end:
  - in_ready=1 during slot N-1 only; 0 in other RUN slots.
  - Transfer during slot N-1 goes directly to slot 0 of a new window, with no idle gap. The new gamma_start is in the next cycle.
  - Slot N-1 without a transfer goes to IDLE. count_out is retained until the next transfer or reset.
- Outputs are registered; spike_out is glitch-free. in_ready may be a combinational decode of state/slot only, never of in_valid.
- Reset mid-window: abort immediately; no pending spike is emitted.
- in_valid while in_ready=0: ignored; upstream must hold the data.

Decomposition:
- Shared package tnn_pkg holds:
  - the default N constant;
  - the CW derivation function;
  - FSM state encodings IDLE=0 and RUN=1.
- One combinational sub-module, therm_decode (N in; count, err out), reused by any later thermometer consumer.
- Slot counter and FSM are kept in therm_spike_tx.

Test Plan (N=16, transfer at edge of cycle 0):
- therm_in=16'h00FF: count_out=8; gamma_start in cycle 1; spike_out only in cycle 9 (slot 8); busy in cycles 1-16; in_ready 0 in cycles 1-15 and 1 in cycle 16.
- therm_in=16'hFFFF: spike in cycle 1, the same cycle as gamma_start. Then therm_in=16'h0000: gamma_start is present, no spike in the whole window, count_out=0.
- therm_in=16'h0001: spike in cycle 16 (slot 15); err=0.
- Malformed therm_in=16'h00F7: count_out=3; err=1 in cycle 1 only; spike in cycle 14 (slot 13).
- Back-to-back: in_valid held high with 16'h000F then 16'h3FFF. Second transfer at cycle 16; gamma_start in cycles 1 and 17; spikes in cycle 13 and cycle 19 (slot 2); busy stays high continuously.
- Reset: accept 16'h000F (spike due cycle 13), assert rst in cycle 5 for one cycle. All outputs are 0 from cycle 6 and no spike appears. in_ready returns to 1 once rst is low.
